// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-outstanding
// request/response port. Define CLINT_MTIME_HALT_EN to add the `halt` input.
module clint #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int          MTIME_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_write,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_strobe,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        trint,
  output logic        swint
`ifdef CLINT_MTIME_HALT_EN
  ,
  input  logic        halt
`endif
);

  // Handshake: a request is taken on any edge where req_valid && req_ready;
  // resp_valid pulses for exactly the following cycle, with no back-pressure.
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  localparam int PW = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;

  state_t        state;
  logic [PW-1:0] presc, presc_next;
  logic [63:0]   mtime, mtime_inc, mtime_next;
  logic [63:0]   mtimecmp, mtimecmp_next;
  logic          msip, msip_next;
  logic [63:0]   offset, wmask, rdata_mux;
  logic          in_range, sel_msip, sel_cmp, sel_time, mapped;
  logic          accept, wr_en, run, tick, resp_valid_q;
  logic          unused_low_bits;

  assign unused_low_bits = ^offset[2:0];

  always_comb begin
    // Below-base addresses wrap to a huge offset, so one upper-bit test covers both ends.
    offset   = req_addr - BASE_ADDR;
    in_range = (offset[63:16] == 48'd0);
    sel_msip = in_range && (offset[15:3] == 13'h0000);
    sel_cmp  = in_range && (offset[15:3] == 13'h0800);
    sel_time = in_range && (offset[15:3] == 13'h17FF);
    mapped   = sel_msip || sel_cmp || sel_time;
    accept   = req_valid && req_ready;
    wr_en    = accept && req_write;
    for (int i = 0; i < 8; i++) wmask[8*i +: 8] = {8{req_strobe[i]}};
  end

  always_comb begin
`ifdef CLINT_MTIME_HALT_EN
    run = !halt;
`else
    run = 1'b1;
`endif
    tick       = run && (presc == PW'(MTIME_DIV - 1));
    presc_next = !run ? presc : (tick ? '0 : presc + PW'(1));
    mtime_inc  = tick ? mtime + 64'd1 : mtime;
    // Written bytes override the increment; unwritten bytes keep counting.
    mtime_next    = (wr_en && sel_time) ? ((req_wdata & wmask) | (mtime_inc & ~wmask)) : mtime_inc;
    mtimecmp_next = (wr_en && sel_cmp) ? ((req_wdata & wmask) | (mtimecmp & ~wmask)) : mtimecmp;
    msip_next     = (wr_en && sel_msip && req_strobe[0]) ? req_wdata[0] : msip;
  end

  always_comb begin
    rdata_mux = 64'd0;
    if (sel_msip)      rdata_mux = {63'd0, msip};
    else if (sel_cmp)  rdata_mux = mtimecmp;
    else if (sel_time) rdata_mux = mtime;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      presc        <= '0;
      mtime        <= 64'd0;
      mtimecmp     <= '1;
      msip         <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata   <= 64'd0;
      resp_err     <= 1'b0;
      trint        <= 1'b0;
      swint        <= 1'b0;
    end else begin
      presc    <= presc_next;
      mtime    <= mtime_next;
      mtimecmp <= mtimecmp_next;
      msip     <= msip_next;
      trint    <= (mtime_next >= mtimecmp_next);
      swint    <= msip_next;
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= RESP;
            req_ready    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata   <= rdata_mux;
            resp_err     <= !mapped;
          end
        end
        RESP: begin
          state        <= IDLE;
          req_ready    <= 1'b1;
          resp_valid_q <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          req_ready    <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // A reset landing in the RESP cycle suppresses the pending response.
  assign resp_valid = resp_valid_q && !reset;

endmodule
